// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings: transfer types, HSIZE values and the FIR slave register map.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;

  typedef enum logic [3:0] {
    FIR_STATUS = 4'h0,
    FIR_RESULT = 4'h2,
    FIR_SAMPLE = 4'h4,
    FIR_F0COEF = 4'h6,
    FIR_F1COEF = 4'h8,
    FIR_F2COEF = 4'hA,
    FIR_F3COEF = 4'hC,
    FIR_COCONF = 4'hE
  } fir_reg_e;

  // Only byte and halfword transfers exist on this bus; anything wider becomes halfword.
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size == HSIZE_BYTE) ? HSIZE_BYTE : HSIZE_HALF;
  endfunction

endpackage

// File: rtl/ahb_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty and a synchronous flush.
module ahb_cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: command queue -> pipelined NONSEQ transfers -> one response each.
// Optional AHB_MASTER_ERR_FLUSH_EN: an error response flushes the queue and sets a sticky err_flag.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
`ifdef AHB_MASTER_ERR_FLUSH_EN
  input  logic                    err_clr,
  output logic                    err_flag,
`endif
  input  logic                    issue_en,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH*8-1:0] cmd_wdata,
  input  logic [2:0]              cmd_size,
  output logic                    rsp_valid,
  output logic                    rsp_write,
  output logic [DATA_WIDTH*8-1:0] rsp_rdata,
  output logic                    rsp_error,
  output logic                    busy,
  output logic                    hsel,
  output logic [1:0]              htrans,
  output logic [ADDR_WIDTH-1:0]   haddr,
  output logic [2:0]              hsize,
  output logic                    hwrite,
  output logic [DATA_WIDTH*8-1:0] hwdata,
  input  logic [DATA_WIDTH*8-1:0] hrdata,
  input  logic                    hresp
);

  localparam int DW = DATA_WIDTH * 8;
  localparam int CW = 1 + ADDR_WIDTH + DW + 3;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DW-1:0]         wdata;
    logic [2:0]            size;
  } cmd_t;

  cmd_t            push_cmd, head_cmd;
  logic [CW-1:0]   head_bits;
  logic            fifo_full, fifo_empty, push, issue, flush, err_block;

  logic            ready_en_q;
  htrans_e         htrans_q, htrans_d;
  logic            hsel_q, hsel_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [2:0]      hsize_q, hsize_d;
  logic            hwrite_q, hwrite_d;
  logic [DW-1:0]   awdata_q, awdata_d;
  logic            dph_valid_q, dph_valid_d;
  logic            dph_write_q, dph_write_d;
  logic [DW-1:0]   hwdata_q, hwdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_write_q, rsp_write_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_error_q, rsp_error_d;

`ifdef AHB_MASTER_ERR_FLUSH_EN
  logic err_flag_q, err_flag_d;

  assign flush     = dph_valid_q && hresp;
  assign err_block = err_flag_q;
  assign err_flag  = err_flag_q;
  assign err_flag_d = flush ? 1'b1 : (err_clr ? 1'b0 : err_flag_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) err_flag_q <= 1'b0;
    else        err_flag_q <= err_flag_d;
  end
`else
  assign flush     = 1'b0;
  assign err_block = 1'b0;
`endif

  // ready_en_q keeps cmd_ready low through reset and for the release edge itself.
  assign cmd_ready = ready_en_q && !fifo_full && !err_block;
  assign push      = cmd_valid && cmd_ready;
  assign issue     = !fifo_empty && issue_en && !flush;
  assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, size: cmd_size};
  assign head_cmd  = cmd_t'(head_bits);

  ahb_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .flush (flush),
    .push  (push),
    .din   (push_cmd),
    .pop   (issue),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Address phase: load the queue head, otherwise IDLE with address/control held.
  always_comb begin
    htrans_d = HTRANS_IDLE;
    hsel_d   = 1'b0;
    haddr_d  = haddr_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    awdata_d = awdata_q;
    if (issue) begin
      htrans_d = HTRANS_NONSEQ;
      hsel_d   = 1'b1;
      hsize_d  = clamp_size(head_cmd.size);
      haddr_d  = head_cmd.addr;
      if (hsize_d == HSIZE_HALF) haddr_d[0] = 1'b0;
      hwrite_d = head_cmd.write;
      awdata_d = head_cmd.wdata;
    end
  end

  // Data phase follows every address phase by one cycle; response is captured as it ends.
  always_comb begin
    dph_valid_d = hsel_q;
    dph_write_d = hwrite_q;
    hwdata_d    = (hsel_q && hwrite_q) ? awdata_q : '0;
    rsp_valid_d = dph_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    if (dph_valid_q) begin
      rsp_write_d = dph_write_q;
      rsp_rdata_d = dph_write_q ? '0 : hrdata;
      rsp_error_d = hresp;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ready_en_q  <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      hsel_q      <= 1'b0;
      haddr_q     <= '0;
      hsize_q     <= '0;
      hwrite_q    <= 1'b0;
      awdata_q    <= '0;
      dph_valid_q <= 1'b0;
      dph_write_q <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      htrans_q    <= htrans_d;
      hsel_q      <= hsel_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      awdata_q    <= awdata_d;
      dph_valid_q <= dph_valid_d;
      dph_write_q <= dph_write_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign htrans    = htrans_q;
  assign hsel      = hsel_q;
  assign haddr     = haddr_q;
  assign hsize     = hsize_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  // Stays high through the final response pulse.
  assign busy      = !fifo_empty || hsel_q || dph_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master with a zero-wait FIR-register slave, a register-map reference model and scoreboards.
module tb_ahb_lite_master;
  import ahb_lite_pkg::*;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          issue_en = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [2:0]    cmd_size = '0;
  logic          cmd_ready, rsp_valid, rsp_write, rsp_error, busy, hsel, hwrite, hresp;
  logic [DW-1:0] rsp_rdata, hwdata, hrdata;
  logic [1:0]    htrans;
  logic [AW-1:0] haddr;
  logic [2:0]    hsize;

  ahb_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .n_rst(n_rst), .issue_en(issue_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy), .hsel(hsel), .htrans(htrans),
    .haddr(haddr), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
    .hrdata(hrdata), .hresp(hresp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIR output: Q1.15 unsigned coefficients, x0 newest sample.
  function automatic logic [15:0] fir(input logic [15:0] c0, c1, c2, c3, x0, x1, x2, x3);
    logic [33:0] acc;
    acc = c0 * x0 + c1 * x1 + c2 * x2 + c3 * x3;
    return acc[30:15];
  endfunction

  // Zero-wait slave: STATUS/RESULT read-only (write -> error), SAMPLE write updates RESULT.
  logic [15:0] s_reg [8];
  logic [15:0] s_hist [3];
  logic        s_dph, s_wr;
  logic [2:0]  s_idx;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s_dph <= 1'b0;
      s_wr  <= 1'b0;
      s_idx <= '0;
      for (int i = 0; i < 8; i++) s_reg[i] <= '0;
      for (int i = 0; i < 3; i++) s_hist[i] <= '0;
    end else begin
      if (s_dph && s_wr && s_idx >= 3'd2) begin
        s_reg[s_idx] <= hwdata;
        if (s_idx == 3'd2) begin
          s_reg[1]  <= fir(s_reg[3], s_reg[4], s_reg[5], s_reg[6], hwdata, s_hist[0], s_hist[1], s_hist[2]);
          s_hist[2] <= s_hist[1];
          s_hist[1] <= s_hist[0];
          s_hist[0] <= hwdata;
        end
      end
      s_dph <= hsel && (htrans == 2'b10);
      s_wr  <= hwrite;
      s_idx <= haddr[3:1];
    end
  end

  assign hresp  = s_dph && s_wr && (s_idx < 3'd2);
  assign hrdata = (s_dph && !s_wr) ? s_reg[s_idx] : '0;

  // Reference model: register map updated in command-acceptance order.
  logic [15:0] m_reg [8];
  logic [15:0] m_hist [3];

  typedef struct { logic wr; logic [15:0] rdata; logic err; } rsp_t;
  typedef struct { logic [3:0] addr; logic [2:0] size; logic wr; logic [15:0] wdata; } bus_t;
  rsp_t exp_q [$];
  bus_t bus_q [$];

  task automatic model_push(input logic w, input logic [3:0] a, input logic [15:0] d, input logic [2:0] s);
    logic [2:0]  idx;
    logic [2:0]  sc;
    logic [3:0]  ea;
    logic        err;
    rsp_t        r;
    bus_t        b;
    idx = a[3:1];
    sc  = (s > 3'd1) ? 3'd1 : s;
    ea  = (sc == 3'd1) ? {a[3:1], 1'b0} : a;
    b   = '{ea, sc, w, d};
    bus_q.push_back(b);
    if (w) begin
      err = (idx < 3'd2);
      if (!err) begin
        m_reg[idx] = d;
        if (idx == 3'd2) begin
          m_reg[1]  = fir(m_reg[3], m_reg[4], m_reg[5], m_reg[6], d, m_hist[0], m_hist[1], m_hist[2]);
          m_hist[2] = m_hist[1];
          m_hist[1] = m_hist[0];
          m_hist[0] = d;
        end
      end
      r = '{1'b1, 16'h0, err};
    end else begin
      r = '{1'b0, m_reg[idx], 1'b0};
    end
    exp_q.push_back(r);
  endtask

  task automatic send(input logic w, input logic [3:0] a, input logic [15:0] d, input logic [2:0] s);
    logic rdy;
    logic accepted;
    int   n;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_size  = s;
    accepted  = 1'b0;
    n = 0;
    while (!accepted && n < 200) begin
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) accepted = 1'b1;
      n++;
    end
    cmd_valid = 1'b0;
    if (accepted) model_push(w, a, d, s);
    else chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  // Response monitor.
  int          rsp_cnt = 0;
  logic        last_wr, last_err;
  logic [15:0] last_rdata;

  always @(negedge clk) begin : rsp_mon
    rsp_t e;
    if (n_rst && rsp_valid) begin
      rsp_cnt++;
      last_wr    = rsp_write;
      last_err   = rsp_error;
      last_rdata = rsp_rdata;
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp{write,rdata,error}", {rsp_write, rsp_rdata, rsp_error}, {e.wr, e.rdata, e.err});
      end
    end
  end

  // Bus monitor: address phase against the expected order, data phase write data.
  int          run = 0;
  int          max_run = 0;
  int          nonseq_cnt = 0;
  logic        dph_pend = 1'b0;
  logic [15:0] exp_hw;

  always @(negedge clk) begin : bus_mon
    bus_t b;
    if (!n_rst) begin
      dph_pend = 1'b0;
      run = 0;
    end else begin
      if (dph_pend) chk("hwdata", hwdata, exp_hw);
      else          chk("hwdata_idle", hwdata, 64'd0);
      dph_pend = 1'b0;
      if (htrans == 2'b10) begin
        run++;
        nonseq_cnt++;
        if (run > max_run) max_run = run;
        if (bus_q.size() == 0) begin
          chk("unexpected_nonseq", 64'd1, 64'd0);
        end else begin
          b = bus_q.pop_front();
          chk("addr_phase{hsel,haddr,hsize,hwrite}", {hsel, haddr, hsize, hwrite}, {1'b1, b.addr, b.size, b.wr});
          dph_pend = 1'b1;
          exp_hw = b.wr ? b.wdata : 16'h0;
        end
      end else begin
        run = 0;
        chk("idle{hsel,htrans}", {hsel, htrans}, 64'd0);
      end
    end
  end

  logic rand_done = 1'b0;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int n, c0, r0;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;

    // Reset values
    #12;
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error, busy, hsel, htrans,
                          haddr, hsize, hwrite, hwdata}, 64'd0);
    #5 n_rst = 1'b1;
    #1 chk("cmd_ready_at_release", cmd_ready, 64'd0);
    @(posedge clk); #1;
    chk("cmd_ready_after_release", cmd_ready, 64'd1);

    // STATUS read: 3-cycle latency, exactly one NONSEQ
    issue_en = 1'b1;
    c0 = nonseq_cnt;
    send(1'b0, FIR_STATUS, 16'h0, 3'd1);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("status_latency", n, 64'd3);
    chk("busy_during_final_rsp", busy, 64'd1);
    wait_idle();
    chk("status_nonseq_count", nonseq_cnt - c0, 64'd1);
    chk("status_rdata", last_rdata, 64'h0);
    chk("status_error", last_err, 64'd0);

    // Back-to-back coefficient writes
    max_run = 0;
    r0 = rsp_cnt;
    send(1'b1, FIR_F0COEF, 16'h4000, 3'd1);
    send(1'b1, FIR_F1COEF, 16'h8000, 3'd1);
    send(1'b1, FIR_F2COEF, 16'h8000, 3'd1);
    send(1'b1, FIR_F3COEF, 16'h4000, 3'd1);
    wait_idle();
    chk("coef_nonseq_run", max_run, 64'd4);
    chk("coef_rsp_count", rsp_cnt - r0, 64'd4);
    send(1'b0, FIR_F1COEF, 16'h0, 3'd1);
    wait_idle();
    chk("f1coef_readback", last_rdata, 64'h8000);

    // Held queue fills at 4; releasing it drains the 4 and the 5th joins the same burst
    issue_en = 1'b0;
    send(1'b0, FIR_F0COEF, 16'h0, 3'd1);
    send(1'b0, FIR_F1COEF, 16'h0, 3'd1);
    send(1'b0, FIR_F2COEF, 16'h0, 3'd1);
    send(1'b0, FIR_F3COEF, 16'h0, 3'd1);
    chk("cmd_ready_full", cmd_ready, 64'd0);
    max_run = 0;
    fork
      send(1'b1, FIR_COCONF, 16'h0001, 3'd1);
      begin
        repeat (3) @(posedge clk);
        #2 issue_en = 1'b1;
      end
    join
    wait_idle();
    chk("drain_nonseq_run", max_run, 64'd5);

    // Write to read-only RESULT errors
    send(1'b1, FIR_RESULT, 16'd50, 3'd1);
    wait_idle();
    chk("result_write_error", {last_wr, last_err}, 64'b11);

    // FIR sample: 0.5 * 100 with empty history
    send(1'b1, FIR_SAMPLE, 16'd100, 3'd1);
    repeat (12) @(posedge clk);
    #1;
    send(1'b0, FIR_RESULT, 16'h0, 3'd1);
    wait_idle();
    chk("fir_result", last_rdata, 64'd50);

    // Randomized traffic with issue_en toggling
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send($urandom_range(0, 1), 4'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #2 issue_en = ($urandom_range(0, 3) != 0);
        end
      end
    join
    issue_en = 1'b1;
    wait_idle();

    // Reset during a data phase drops the transfer
    r0 = rsp_cnt;
    send(1'b0, FIR_F0COEF, 16'h0, 3'd1);
    @(posedge clk);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midreset_outputs", {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error, busy, hsel, htrans,
                             haddr, hsize, hwrite, hwdata}, 64'd0);
    exp_q.delete();
    bus_q.delete();
    repeat (2) @(posedge clk);
    #3 n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_reset{rsp_valid,busy}", {rsp_valid, busy}, 64'd0);
    end
    chk("dropped_rsp_count", rsp_cnt - r0, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
